// File: rtl/int_ctrl.sv
// int_ctrl: eight-line vectored interrupt controller with edge capture,
// enable mask, fixed priority (bit 0 highest) and in-service nesting.
module int_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] int_e,
  input  logic       mask_we,
  input  logic [7:0] mask_d,
  input  logic       ack,
  input  logic       eoi,
  output logic       irq,
  output logic [2:0] int_id,
  output logic [7:0] int_a,
  output logic [7:0] pending,
  output logic [7:0] in_service,
  output logic [7:0] mask
);

  typedef enum logic {
    IDLE,
    REQ
  } state_t;

  state_t     state;
  logic [7:0] prev;
  logic [7:0] edge_v;
  logic [7:0] cand_v;
  logic [7:0] ack_set;
  logic [7:0] eoi_clr;
  logic [2:0] cand_id;
  logic [2:0] is_id;
  logic       is_any;
  logic       eligible;

  function automatic logic [2:0] low_idx(input logic [7:0] v);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) r = 3'(i);
    end
    return r;
  endfunction

  assign edge_v  = int_e & ~prev;
  assign cand_v  = pending & mask;
  assign cand_id = low_idx(cand_v);
  assign is_id   = low_idx(in_service);
  assign is_any  = |in_service;

  // Nesting only for strictly higher priority than the
  // highest-priority interrupt currently in service.
  assign eligible = (|cand_v) && (!is_any || (cand_id < is_id));

  assign ack_set = (state == REQ && ack) ? (8'd1 << int_id) : 8'd0;

  // Lowest set bit of in_service, taken from the pre-edge value.
  assign eoi_clr = eoi ? (in_service & (~in_service + 8'd1)) : 8'd0;

  assign int_a = irq ? (8'd1 << int_id) : 8'd0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      prev       <= 8'hFF;
      pending    <= 8'h00;
      in_service <= 8'h00;
      mask       <= 8'h00;
      irq        <= 1'b0;
      int_id     <= 3'd0;
    end else begin
      prev <= int_e;
      if (mask_we) mask <= mask_d;
      // A fresh edge wins over the ack clear of the same line.
      pending    <= (pending & ~ack_set) | edge_v;
      in_service <= (in_service & ~eoi_clr) | ack_set;
      unique case (state)
        IDLE: begin
          if (eligible) begin
            state  <= REQ;
            irq    <= 1'b1;
            int_id <= cand_id;
          end
        end
        REQ: begin
          if (ack) begin
            state <= IDLE;
            irq   <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          irq   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_int_ctrl.sv
// tb_int_ctrl: directed stimulus with a request scoreboard; a monitor
// pops the expected id and cycle on every rising irq.
module tb_int_ctrl;

  logic       clk;
  logic       reset;
  logic [7:0] int_e;
  logic       mask_we;
  logic [7:0] mask_d;
  logic       ack;
  logic       eoi;
  logic       irq;
  logic [2:0] int_id;
  logic [7:0] int_a;
  logic [7:0] pending;
  logic [7:0] in_service;
  logic [7:0] mask;

  int_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .int_e     (int_e),
    .mask_we   (mask_we),
    .mask_d    (mask_d),
    .ack       (ack),
    .eoi       (eoi),
    .irq       (irq),
    .int_id    (int_id),
    .int_a     (int_a),
    .pending   (pending),
    .in_service(in_service),
    .mask      (mask)
  );

  typedef struct {
    logic [2:0] id;
    int         cyc;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  logic irq_q    = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h cyc=%0d", name, act, exp, cyc);
    end
  endtask

  // Monitor: every new request must match the next expected entry.
  always @(negedge clk) begin
    exp_t e;
    if (irq && !irq_q) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_irq got id=%0d cyc=%0d exp none",
                 int_id, cyc);
      end else begin
        e = q.pop_front();
        chk("req_id", {5'd0, int_id}, {5'd0, e.id});
        chk("req_int_a", int_a, 8'd1 << e.id);
        checks++;
        if (cyc != e.cyc) begin
          failures++;
          $display("FAIL req_cycle got=%0d exp=%0d", cyc, e.cyc);
        end
      end
    end
    irq_q = irq;
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic expect_req(input logic [2:0] id, input int lat);
    exp_t e;
    e.id  = id;
    e.cyc = cyc + lat;
    q.push_back(e);
  endtask

  task automatic pulse_line(input int i);
    int_e = 8'd1 << i;
    step();
    int_e = 8'h00;
  endtask

  initial begin
    reset   = 1'b1;
    int_e   = 8'hFF;
    mask_we = 1'b0;
    mask_d  = 8'h00;
    ack     = 1'b0;
    eoi     = 1'b0;
    step();
    step();
    chk("rst_pending", pending, 8'h00);
    chk("rst_in_service", in_service, 8'h00);
    chk("rst_mask", mask, 8'h00);
    chk("rst_irq", {7'd0, irq}, 8'h00);
    chk("rst_int_a", int_a, 8'h00);
    // Lines held high through reset release are not edges
    reset = 1'b0;
    step();
    step();
    chk("held_high_pending", pending, 8'h00);
    int_e = 8'h00;
    step();
    chk("fall_pending", pending, 8'h00);

    // Basic request on line 5
    mask_we = 1'b1;
    mask_d  = 8'hFF;
    step();
    mask_we = 1'b0;
    chk("mask_ff", mask, 8'hFF);
    expect_req(3'd5, 2);
    pulse_line(5);
    chk("basic_pending", pending, 8'h20);
    chk("basic_irq_low", {7'd0, irq}, 8'h00);
    step();
    chk("basic_int_a", int_a, 8'h20);
    ack = 1'b1;
    step();
    ack = 1'b0;
    chk("basic_ack_irq", {7'd0, irq}, 8'h00);
    chk("basic_ack_is", in_service, 8'h20);
    chk("basic_ack_pend", pending, 8'h00);
    eoi = 1'b1;
    step();
    eoi = 1'b0;
    chk("basic_eoi_is", in_service, 8'h00);
    eoi = 1'b1;
    step();
    eoi = 1'b0;
    chk("idle_eoi_is", in_service, 8'h00);
    chk("idle_eoi_pend", pending, 8'h00);
    chk("idle_eoi_irq", {7'd0, irq}, 8'h00);

    // Priority: 2 beats 6, 6 waits for eoi
    expect_req(3'd2, 2);
    int_e = 8'h44;
    step();
    int_e = 8'h00;
    step();
    ack = 1'b1;
    step();
    ack = 1'b0;
    chk("prio_is", in_service, 8'h04);
    chk("prio_pend", pending, 8'h40);
    step();
    step();
    chk("prio_no_irq", {7'd0, irq}, 8'h00);
    expect_req(3'd6, 2);
    eoi = 1'b1;
    step();
    eoi = 1'b0;
    chk("prio_eoi_is", in_service, 8'h00);
    step();
    ack = 1'b1;
    step();
    ack = 1'b0;
    chk("prio6_is", in_service, 8'h40);
    eoi = 1'b1;
    step();
    eoi = 1'b0;
    chk("prio6_eoi_is", in_service, 8'h00);

    // Nesting under line 4
    expect_req(3'd4, 2);
    pulse_line(4);
    step();
    ack = 1'b1;
    step();
    ack = 1'b0;
    chk("nest_is4", in_service, 8'h10);
    expect_req(3'd1, 2);
    pulse_line(1);
    step();
    ack = 1'b1;
    step();
    ack = 1'b0;
    chk("nest_is12", in_service, 8'h12);
    eoi = 1'b1;
    step();
    eoi = 1'b0;
    chk("nest_eoi1", in_service, 8'h10);
    // Simultaneous ack and eoi: eoi clears 4, ack sets 2
    expect_req(3'd2, 2);
    pulse_line(2);
    step();
    ack = 1'b1;
    eoi = 1'b1;
    step();
    ack = 1'b0;
    eoi = 1'b0;
    chk("ack_eoi_is", in_service, 8'h04);
    eoi = 1'b1;
    step();
    eoi = 1'b0;
    chk("nest_eoi2", in_service, 8'h00);

    // Masking holds a pending line until enabled
    mask_we = 1'b1;
    mask_d  = 8'h00;
    step();
    mask_we = 1'b0;
    pulse_line(3);
    chk("mask_pend", pending, 8'h08);
    step();
    step();
    chk("mask_no_irq", {7'd0, irq}, 8'h00);
    expect_req(3'd3, 2);
    mask_we = 1'b1;
    mask_d  = 8'h08;
    step();
    mask_we = 1'b0;
    chk("mask_08", mask, 8'h08);
    step();
    ack = 1'b1;
    step();
    ack = 1'b0;
    eoi = 1'b1;
    step();
    eoi = 1'b0;
    chk("mask_done_is", in_service, 8'h00);

    // Frozen request and same-cycle edge/ack race
    mask_we = 1'b1;
    mask_d  = 8'hFF;
    step();
    mask_we = 1'b0;
    expect_req(3'd4, 2);
    pulse_line(4);
    step();
    pulse_line(0);
    chk("frozen_id", {5'd0, int_id}, 8'h04);
    chk("frozen_irq", {7'd0, irq}, 8'h01);
    chk("frozen_pend", pending, 8'h11);
    int_e = 8'h10;
    ack   = 1'b1;
    step();
    int_e = 8'h00;
    ack   = 1'b0;
    chk("race_pend", pending, 8'h11);
    chk("race_is", in_service, 8'h10);
    expect_req(3'd0, 1);
    step();
    ack = 1'b1;
    step();
    ack = 1'b0;
    chk("race_is11", in_service, 8'h11);
    chk("race_pend10", pending, 8'h10);
    eoi = 1'b1;
    step();
    eoi = 1'b0;
    chk("race_eoi_is", in_service, 8'h10);
    step();
    chk("same_prio_no_irq", {7'd0, irq}, 8'h00);
    expect_req(3'd4, 2);
    eoi = 1'b1;
    step();
    eoi = 1'b0;
    step();
    chk("final_req_int_a", int_a, 8'h10);

    // Reset during an active request
    reset = 1'b1;
    step();
    chk("midrst_irq", {7'd0, irq}, 8'h00);
    chk("midrst_id", {5'd0, int_id}, 8'h00);
    chk("midrst_int_a", int_a, 8'h00);
    chk("midrst_pend", pending, 8'h00);
    chk("midrst_is", in_service, 8'h00);
    chk("midrst_mask", mask, 8'h00);
    reset = 1'b0;
    step();
    step();

    while (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      failures++;
      $display("FAIL missing_irq got none exp id=%0d cyc=%0d", e.id, e.cyc);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
